// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns, one 32-bit column per cycle through a shared column multiplier.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid/in_ready/in_data     128-bit state input handshake (col c = in_data[127-32c -: 32], byte0 = col[31:24])
//   out_valid/out_ready/out_data  128-bit result handshake, same ordering
//   inv        present only with MIX_COLUMNS_INV_EN: 1 selects inverse MixColumns, latched on accept
module mix_columns_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef MIX_COLUMNS_INV_EN
  ,
  input  logic         inv
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t       r_state;
  logic [1:0]   r_cnt;
  logic [127:0] r_src;
  logic [127:0] r_res;
  logic         r_out_valid;
  logic [31:0]  w_col;
  logic [31:0]  w_mix;
  logic         w_acc;
`ifdef MIX_COLUMNS_INV_EN
  logic         r_inv;
`endif

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] fwd_row(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    return xt(a) ^ xt(b) ^ b ^ c ^ d;
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] x);
    return {fwd_row(x[31:24], x[23:16], x[15:8], x[7:0]),
            fwd_row(x[23:16], x[15:8], x[7:0], x[31:24]),
            fwd_row(x[15:8], x[7:0], x[31:24], x[23:16]),
            fwd_row(x[7:0], x[31:24], x[23:16], x[15:8])};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  // 14a ^ 11b ^ 13c ^ 9d using x2/x4/x8 taps of the xtime chain
  function automatic logic [7:0] inv_row(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    logic [7:0] a2, a4, b2, b4, c2, c4, d2, d4;
    a2 = xt(a); a4 = xt(a2);
    b2 = xt(b); b4 = xt(b2);
    c2 = xt(c); c4 = xt(c2);
    d2 = xt(d); d4 = xt(d2);
    return xt(a4) ^ a4 ^ a2 ^ xt(b4) ^ b2 ^ b ^ xt(c4) ^ c4 ^ c ^ xt(d4) ^ d;
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] x);
    return {inv_row(x[31:24], x[23:16], x[15:8], x[7:0]),
            inv_row(x[23:16], x[15:8], x[7:0], x[31:24]),
            inv_row(x[15:8], x[7:0], x[31:24], x[23:16]),
            inv_row(x[7:0], x[31:24], x[23:16], x[15:8])};
  endfunction
`endif

  // column 0 sits in the top 32 bits, so the bit offset is ~cnt * 32
  assign w_col = r_src[{~r_cnt, 5'd0} +: 32];
`ifdef MIX_COLUMNS_INV_EN
  assign w_mix = r_inv ? inv_col(w_col) : fwd_col(w_col);
`else
  assign w_mix = fwd_col(w_col);
`endif
  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_acc     = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 2'd0;
      r_src       <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      if (w_acc) begin
        r_src <= in_data;
        r_cnt <= 2'd0;
`ifdef MIX_COLUMNS_INV_EN
        r_inv <= inv;
`endif
      end
      unique case (r_state)
        IDLE: r_state <= w_acc ? BUSY : IDLE;
        BUSY: begin
          r_res[{~r_cnt, 5'd0} +: 32] <= w_mix;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= in_valid ? BUSY : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: scoreboard bench for mix_columns_iter against a GF(2^8) matrix reference model.
module tb_mix_columns_iter;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [127:0] out_data;
`ifdef MIX_COLUMNS_INV_EN
  logic         inv = 0;
`endif
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  logic rnd_rdy = 0;
  logic prev_valid = 0;
  typedef struct {logic [127:0] exp; int acc;} item_t;
  item_t q[$];

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] BP_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] BP_OUT   = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  mix_columns_iter dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef MIX_COLUMNS_INV_EN
    , .inv(inv)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    logic hi;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      hi = x[7];
      x = {x[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // out byte (col, row) = sum over c of coef[(c-row) mod 4] * in byte (col, c)
  function automatic logic [127:0] model(input logic [127:0] d, input logic iv);
    logic [7:0] k[4];
    logic [7:0] acc;
    logic [127:0] r;
    if (iv) begin k[0] = 14; k[1] = 11; k[2] = 13; k[3] = 9; end
    else    begin k[0] = 2;  k[1] = 3;  k[2] = 1;  k[3] = 1; end
    r = '0;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++) begin
        acc = 0;
        for (int c = 0; c < 4; c++) acc ^= gmul(k[(c - row) & 3], d[127 - 32*col - 8*c -: 8]);
        r[127 - 32*col - 8*row -: 8] = acc;
      end
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic iv, input logic [127:0] e);
    int n;
    n = 0;
    in_valid = 1;
    in_data = d;
`ifdef MIX_COLUMNS_INV_EN
    inv = iv;
`else
    if (iv) $display("inverse block requested in forward-only build");
`endif
    while (!in_ready && n < 80) begin tick(); n++; end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL accept: in_ready stuck at 0 for %0d cycles", n);
    end else begin
      q.push_back('{e, cyc + 1});
      last_acc = cyc + 1;
    end
    tick();
    in_valid = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 300) begin tick(); n++; end
    check("drain", 128'(q.size()), 128'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check("wait_valid", {127'd0, out_valid}, 128'd1);
  endtask

  initial forever begin
    @(negedge clk);
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(negedge clk);
    #3;
    if (!rst_n) prev_valid = 0;
    else begin
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) check("spurious_valid", {127'd0, out_valid}, 128'd0);
        else check("latency", 128'(cyc - q[0].acc), 128'd4);
      end
      if (out_valid && q.size() > 0) begin
        check("out_data", out_data, q[0].exp);
        if (!out_ready) check("in_ready_stall", {127'd0, in_ready}, 128'd0);
        else void'(q.pop_front());
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    logic [127:0] d, a;
    int acc_a;
    #12;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    tick();
    rst_n = 1;
    tick();
    out_ready = 1;
    send(FIPS_IN, 0, FIPS_OUT);
    wait_drain();
    send(FIPS_IN, 0, FIPS_OUT);
    in_valid = 1;
    in_data = ~FIPS_IN;
    check("busy_in_ready0", {127'd0, in_ready}, 128'd0);
    tick();
    check("busy_in_ready1", {127'd0, in_ready}, 128'd0);
    tick();
    in_valid = 0;
    wait_drain();
    out_ready = 0;
    send(BP_IN, 0, BP_OUT);
    wait_valid();
    repeat (10) tick();
    check("bp_hold", out_data, BP_OUT);
    out_ready = 1;
    tick();
    check("bp_handoff", {127'd0, out_valid}, 128'd0);
    check("bp_queue", 128'(q.size()), 128'd0);
    a = {$urandom, $urandom, $urandom, $urandom};
    d = {$urandom, $urandom, $urandom, $urandom};
    send(a, 0, model(a, 0));
    acc_a = last_acc;
    send(d, 0, model(d, 0));
    check("b2b_gap", 128'(last_acc - acc_a), 128'd5);
    wait_drain();
    out_ready = 0;
    d = {$urandom | 32'h1, $urandom, $urandom, $urandom};
    send(d, 0, model(d, 0));
    wait_valid();
    #3;
    rst_n = 0;
    #1;
    check("async_rst_valid", {127'd0, out_valid}, 128'd0);
    check("async_rst_data", out_data, 128'd0);
    check("async_rst_ready", {127'd0, in_ready}, 128'd1);
    q.delete();
    tick();
    rst_n = 1;
    tick();
    rnd_rdy = 1;
    send({128{1'b1}}, 0, model({128{1'b1}}, 0));
    send({16{8'h80}}, 0, model({16{8'h80}}, 0));
    send(128'd0, 0, 128'd0);
    repeat (150) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 0, model(d, 0));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain();
`ifdef MIX_COLUMNS_INV_EN
    send(FIPS_OUT, 1, FIPS_IN);
    repeat (1000) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(model(d, 0), 1, d);
      if ($urandom_range(0, 3) == 0) send(d, 0, model(d, 0));
    end
    wait_drain();
`endif
    rnd_rdy = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
